// File: rtl/rsa_job_scheduler.sv
// Two-requester front end for one shared RSA control core: round-robin accept,
// key cache to skip the inverter phase, per-phase watchdog, held response.
module rsa_job_scheduler #(
  parameter int WIDTH          = 128,
  parameter int TIMEOUT_CYCLES = 1048575
) (
  input  logic                 clk,
  input  logic                 reset_n,

  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_p,
  input  logic [WIDTH-1:0]     req0_q,
  input  logic                 req0_ed,
  input  logic [2*WIDTH-1:0]   req0_msg,

  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_p,
  input  logic [WIDTH-1:0]     req1_q,
  input  logic                 req1_ed,
  input  logic [2*WIDTH-1:0]   req1_msg,

  output logic [WIDTH-1:0]     core_p,
  output logic [WIDTH-1:0]     core_q,
  output logic                 core_encrypt_decrypt,
  output logic [2*WIDTH-1:0]   core_msg_in,
  output logic                 core_reset_inverter,
  output logic                 core_reset_mod_exp,
  input  logic                 core_inverter_finish,
  input  logic                 core_mod_exp_finish,
  input  logic [2*WIDTH-1:0]   core_msg_out,

  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [2*WIDTH-1:0]   rsp_msg,
  output logic                 rsp_timeout
);

  typedef struct packed {
    logic [WIDTH-1:0]   p;
    logic [WIDTH-1:0]   q;
    logic               ed;
    logic [2*WIDTH-1:0] msg;
  } job_t;

  typedef enum logic [2:0] {
    IDLE, INV_PULSE, INV_WAIT, EXP_PULSE, EXP_WAIT, RESP
  } state_t;

  localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES);

  state_t      state, state_nx;
  job_t        op_q, req_job;
  logic [1:0]  gnt;
  logic        last_gnt;
  logic        key_valid;
  logic        key_hit;
  logic        accept;
  logic [31:0] wd_cnt;
  logic        wd_first, wd_expired;
  logic        in_wait;
  logic        inv_done, exp_done, wd_to;

  // Round-robin: on contention the requester not granted last time wins.
  // last_gnt resets to 1 so requester 0 takes the first contention.
  always_comb begin
    gnt = 2'b00;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) gnt = last_gnt ? 2'b01 : 2'b10;
      else if (req0_valid)          gnt = 2'b01;
      else if (req1_valid)          gnt = 2'b10;
    end
  end

  assign accept     = |gnt;
  assign req0_ready = gnt[0] & reset_n;
  assign req1_ready = gnt[1] & reset_n;

  always_comb begin
    if (gnt[1]) req_job = '{p: req1_p, q: req1_q, ed: req1_ed, msg: req1_msg};
    else        req_job = '{p: req0_p, q: req0_q, ed: req0_ed, msg: req0_msg};
  end

  // Operand registers still hold the previous job's key at accept time.
  assign key_hit = key_valid && (req_job.p == op_q.p) && (req_job.q == op_q.q) &&
                   (req_job.ed == op_q.ed);

  // Counter is cleared in the pulse state, so 0 marks the first wait cycle,
  // where a finish left over from the previous job may still be visible.
  assign in_wait    = (state == INV_WAIT) || (state == EXP_WAIT);
  assign wd_first   = (wd_cnt == 32'd0);
  assign wd_expired = ((wd_cnt + 32'd1) == TO_LIM);
  assign inv_done   = (state == INV_WAIT) && !wd_first && core_inverter_finish;
  assign exp_done   = (state == EXP_WAIT) && !wd_first && core_mod_exp_finish;
  assign wd_to      = in_wait && wd_expired && !inv_done && !exp_done;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (accept) state_nx = key_hit ? EXP_PULSE : INV_PULSE;
      INV_PULSE: state_nx = INV_WAIT;
      INV_WAIT: begin
        if (inv_done)   state_nx = EXP_PULSE;
        else if (wd_to) state_nx = RESP;
      end
      EXP_PULSE: state_nx = EXP_WAIT;
      EXP_WAIT:  if (exp_done || wd_to) state_nx = RESP;
      RESP:      if (rsp_ready) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      op_q        <= '0;
      last_gnt    <= 1'b1;
      key_valid   <= 1'b0;
      wd_cnt      <= '0;
      rsp_id      <= 1'b0;
      rsp_msg     <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_nx;

      if (accept) begin
        op_q     <= req_job;
        rsp_id   <= gnt[1];
        last_gnt <= gnt[1];
        if (!key_hit) key_valid <= 1'b0;
      end

      if ((state == INV_PULSE) || (state == EXP_PULSE)) wd_cnt <= '0;
      else if (in_wait)                                 wd_cnt <= wd_cnt + 32'd1;

      if (inv_done) key_valid <= 1'b1;

      if (exp_done) begin
        rsp_msg     <= core_msg_out;
        rsp_timeout <= 1'b0;
      end else if (wd_to) begin
        rsp_msg     <= '0;
        rsp_timeout <= 1'b1;
        key_valid   <= 1'b0;
      end
    end
  end

  assign core_p               = op_q.p;
  assign core_q               = op_q.q;
  assign core_encrypt_decrypt = op_q.ed;
  assign core_msg_in          = op_q.msg;
  assign core_reset_inverter  = (state == INV_PULSE);
  assign core_reset_mod_exp   = (state == EXP_PULSE);
  assign rsp_valid            = (state == RESP);

endmodule

// File: tb/tb_rsa_job_scheduler.sv
// Bench for rsa_job_scheduler: directed table + random jobs against a job-level
// model of grant order, key cache and watchdog, with a behavioural core stub.
module tb_rsa_job_scheduler;
  localparam int W  = 128;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic           req0_valid, req0_ready, req0_ed;
  logic [W-1:0]   req0_p, req0_q;
  logic [2*W-1:0] req0_msg;
  logic           req1_valid, req1_ready, req1_ed;
  logic [W-1:0]   req1_p, req1_q;
  logic [2*W-1:0] req1_msg;
  logic [W-1:0]   core_p, core_q;
  logic           core_encrypt_decrypt, core_reset_inverter, core_reset_mod_exp;
  logic [2*W-1:0] core_msg_in, core_msg_out;
  logic           core_inverter_finish, core_mod_exp_finish;
  logic           rsp_valid, rsp_ready, rsp_id, rsp_timeout;
  logic [2*W-1:0] rsp_msg;

  rsa_job_scheduler #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_p(req0_p), .req0_q(req0_q),
    .req0_ed(req0_ed), .req0_msg(req0_msg),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_p(req1_p), .req1_q(req1_q),
    .req1_ed(req1_ed), .req1_msg(req1_msg),
    .core_p(core_p), .core_q(core_q), .core_encrypt_decrypt(core_encrypt_decrypt),
    .core_msg_in(core_msg_in), .core_reset_inverter(core_reset_inverter),
    .core_reset_mod_exp(core_reset_mod_exp), .core_inverter_finish(core_inverter_finish),
    .core_mod_exp_finish(core_mod_exp_finish), .core_msg_out(core_msg_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_msg(rsp_msg),
    .rsp_timeout(rsp_timeout)
  );

  typedef struct {
    logic [W-1:0]   p, q;
    logic           ed;
    logic [2*W-1:0] msg;
  } job_t;

  typedef struct {
    bit   v0, v1;
    job_t j0, j1;
    bit   never_inv, never_exp, hold;
    int   rdly;
    int   e_gnt;
    bit   e_inv, e_to;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Core stub: finish flags stay high after completion and only drop one cycle
  // after the start pulse, so a stale finish is visible in the first wait cycle.
  bit cm_never_inv, cm_never_exp;
  int cm_dly;
  bit inv_clr, exp_clr;
  int inv_cnt, exp_cnt;

  function automatic logic [2*W-1:0] fmsg(logic [2*W-1:0] m, logic [W-1:0] p, logic [W-1:0] q, logic ed);
    return (m ^ {p, q}) + {{(2*W-1){1'b0}}, ed};
  endfunction

  initial begin
    core_inverter_finish = 1'b0; core_mod_exp_finish = 1'b0; core_msg_out = '0;
    inv_clr = 1'b0; exp_clr = 1'b0; inv_cnt = 0; exp_cnt = 0;
  end

  always @(posedge clk) begin
    if (core_reset_inverter) inv_clr <= 1'b1;
    else if (inv_clr) begin
      inv_clr <= 1'b0; core_inverter_finish <= 1'b0;
      inv_cnt <= cm_never_inv ? 0 : cm_dly;
    end else if (inv_cnt > 0) begin
      inv_cnt <= inv_cnt - 1;
      if (inv_cnt == 1) core_inverter_finish <= 1'b1;
    end
    if (core_reset_mod_exp) exp_clr <= 1'b1;
    else if (exp_clr) begin
      exp_clr <= 1'b0; core_mod_exp_finish <= 1'b0;
      exp_cnt <= cm_never_exp ? 0 : cm_dly;
    end else if (exp_cnt > 0) begin
      exp_cnt <= exp_cnt - 1;
      if (exp_cnt == 1) begin
        core_mod_exp_finish <= 1'b1;
        core_msg_out <= fmsg(core_msg_in, core_p, core_q, core_encrypt_decrypt);
      end
    end
  end

  // Job-level reference state
  int   m_last;
  bit   m_kv;
  job_t m_key;

  task automatic chk(input string name, input logic [519:0] act, input logic [519:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic job_t mkj(logic [W-1:0] p, logic [W-1:0] q, logic ed, logic [2*W-1:0] m);
    job_t j; j.p = p; j.q = q; j.ed = ed; j.msg = m; return j;
  endfunction

  function automatic vec_t mk(bit v0, bit v1, job_t j0, job_t j1, bit ni, bit ne, bit hold,
                              int rdly, int eg, bit ei, bit eto);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.j0 = j0; v.j1 = j1; v.never_inv = ni; v.never_exp = ne;
    v.hold = hold; v.rdly = rdly; v.e_gnt = eg; v.e_inv = ei; v.e_to = eto;
    return v;
  endfunction

  function automatic void predict(inout vec_t v);
    job_t j; bit hit;
    if (v.v0 && v.v1) v.e_gnt = (m_last == 1) ? 0 : 1;
    else              v.e_gnt = v.v0 ? 0 : 1;
    j = v.e_gnt ? v.j1 : v.j0;
    hit = m_kv && (j.p == m_key.p) && (j.q == m_key.q) && (j.ed == m_key.ed);
    v.e_inv = !hit;
    v.e_to  = (!hit && v.never_inv) || v.never_exp;
  endfunction

  task automatic run_job(input vec_t v);
    job_t j; logic [2*W-1:0] emsg; logic [2*W+2:0] snap;
    int t_inv, t_exp, t_rsp, n_inv, n_exp, bad; bit inv_to;
    j = v.e_gnt ? v.j1 : v.j0;
    inv_to = v.e_inv && v.never_inv;
    emsg = v.e_to ? '0 : fmsg(j.msg, j.p, j.q, j.ed);
    cm_never_inv = v.never_inv; cm_never_exp = v.never_exp; cm_dly = $urandom_range(1, 5);
    req0_valid = v.v0; req0_p = v.j0.p; req0_q = v.j0.q; req0_ed = v.j0.ed; req0_msg = v.j0.msg;
    req1_valid = v.v1; req1_p = v.j1.p; req1_q = v.j1.q; req1_ed = v.j1.ed; req1_msg = v.j1.msg;
    #1;
    chk("grant", {req1_ready, req0_ready}, (v.e_gnt == 1) ? 2'b10 : 2'b01);
    t_inv = 0; t_exp = 0; t_rsp = 0; n_inv = 0; n_exp = 0; bad = 0;
    for (int k = 1; k <= 300 && t_rsp == 0; k++) begin
      @(negedge clk);
      if (core_reset_inverter) begin n_inv++; if (t_inv == 0) t_inv = k; end
      if (core_reset_mod_exp)  begin n_exp++; if (t_exp == 0) t_exp = k; end
      if (req0_ready || req1_ready) bad++;
      if (rsp_valid) t_rsp = k;
      if (!v.hold) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_p = {4{$urandom}}; req1_msg = {8{$urandom}}; req0_ed = ~req0_ed;
      end
    end
    chk("rsp_seen", t_rsp != 0, 1'b1);
    chk("inv_pulses", n_inv, v.e_inv);
    chk("exp_pulses", n_exp, inv_to ? 0 : 1);
    chk("first_pulse_cycle", v.e_inv ? t_inv : t_exp, 1);
    if (inv_to)      chk("inv_timeout_cycle", t_rsp - t_inv, TO + 1);
    else if (v.e_to) chk("exp_timeout_cycle", t_rsp - t_exp, TO + 1);
    chk("ready_while_busy", bad, 0);
    chk("rsp_id", rsp_id, v.e_gnt);
    chk("rsp_msg", rsp_msg, emsg);
    chk("rsp_timeout", rsp_timeout, v.e_to);
    chk("core_operands", {core_p, core_q, core_encrypt_decrypt, core_msg_in}, {j.p, j.q, j.ed, j.msg});
    snap = {rsp_valid, rsp_id, rsp_timeout, rsp_msg};
    bad = 0;
    for (int k = 0; k < v.rdly; k++) begin
      @(negedge clk);
      if ({rsp_valid, rsp_id, rsp_timeout, rsp_msg} !== snap || req0_ready || req1_ready) bad++;
    end
    chk("resp_hold", bad, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_released", rsp_valid, 1'b0);
    rsp_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    m_last = v.e_gnt;
    m_key = j;
    m_kv = !v.e_to;
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_core"}, {req0_ready, req1_ready, core_p, core_q, core_encrypt_decrypt,
                          core_msg_in, core_reset_inverter, core_reset_mod_exp}, '0);
    chk({name, "_rsp"}, {rsp_valid, rsp_id, rsp_timeout, rsp_msg}, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "bench time limit");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    job_t ja, jb, jc, k0, k1;
    int n;

    ja = mkj(128'd113680897410347, 128'd7999808077935876437321, 1'b0, 256'h7b2800000000);
    jb = mkj(128'd1000003, 128'd998244353, 1'b1, 256'h1234_5678_9abc_def0_1111);
    jc = mkj(128'd65537, 128'd2147483647, 1'b0, 256'hdead_beef_0000_cafe);

    //          v0 v1 j0  j1  ni ne hold rdly gnt inv to
    tbl.push_back(mk(1, 0, ja, jc, 0, 0, 0, 0,  0, 1, 0));  // first job: full flow
    tbl.push_back(mk(0, 1, jc, ja, 0, 0, 0, 0,  1, 0, 0));  // same key on req1: cache hit
    tbl.push_back(mk(1, 1, jb, jc, 0, 0, 1, 1,  0, 1, 0));  // contention x4
    tbl.push_back(mk(1, 1, jb, jc, 0, 0, 1, 2,  1, 1, 0));
    tbl.push_back(mk(1, 1, jb, jc, 0, 0, 1, 0,  0, 1, 0));
    tbl.push_back(mk(1, 1, jb, jc, 0, 0, 1, 3,  1, 1, 0));
    tbl.push_back(mk(1, 0, ja, jb, 1, 0, 1, 10, 0, 1, 1));  // inverter timeout, long rsp stall
    tbl.push_back(mk(1, 0, ja, jb, 0, 0, 0, 0,  0, 1, 0));  // key dropped: inverter reruns
    tbl.push_back(mk(0, 1, jb, ja, 0, 1, 0, 2,  1, 0, 1));  // hit, mod_exp timeout
    tbl.push_back(mk(1, 0, ja, jb, 0, 0, 0, 1,  0, 1, 0));  // key dropped again

    reset_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_p = '0; req0_q = '0; req0_ed = 1'b0; req0_msg = '0;
    req1_p = '0; req1_q = '0; req1_ed = 1'b0; req1_msg = '0;
    cm_never_inv = 1'b0; cm_never_exp = 1'b0; cm_dly = 1;
    m_last = 1; m_kv = 1'b0; m_key = ja;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset_state");
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) run_job(tbl[i]);

    // Random jobs over a two-key pool so both hits and misses occur.
    k0 = jb; k1 = jc;
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(1, 3);
      v.v0 = n[0]; v.v1 = n[1];
      v.j0 = ($urandom_range(0, 1) == 0) ? k0 : k1; v.j0.msg = {8{$urandom}};
      v.j1 = ($urandom_range(0, 1) == 0) ? k0 : k1; v.j1.msg = {8{$urandom}};
      v.never_inv = ($urandom_range(0, 7) == 0);
      v.never_exp = ($urandom_range(0, 7) == 0);
      v.hold = $urandom_range(0, 1);
      v.rdly = $urandom_range(0, 3);
      predict(v);
      run_job(v);
    end

    // Reset while waiting on mod_exp: no response, outputs cleared at once.
    cm_never_inv = 1'b0; cm_never_exp = 1'b1; cm_dly = 2;
    req0_valid = 1'b1; req0_p = ja.p; req0_q = ja.q; req0_ed = ja.ed; req0_msg = ja.msg;
    n = 0;
    while (!core_reset_mod_exp && n < 100) begin @(negedge clk); n++; end
    chk("reached_exp_phase", core_reset_mod_exp, 1'b1);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_reset_outs("reset_mid_job");
    req0_valid = 1'b0;
    @(negedge clk);
    chk("reset_no_pulse", {core_reset_inverter, core_reset_mod_exp, rsp_valid}, 3'b000);
    reset_n = 1'b1;
    m_last = 1; m_kv = 1'b0;
    @(negedge clk);
    v = mk(1, 0, ja, jb, 0, 0, 0, 1, 0, 1, 0);
    predict(v);
    chk("model_after_reset", {v.e_inv, v.e_to}, 2'b10);
    run_job(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rsa_job_scheduler.md
RSA_JOB_SCHEDULER -- requirements
Module: rsa_job_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 128: prime width; message width is 2*WIDTH.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1048575: per-phase watchdog limit; 32-bit counter.
REQ-003 SHALL have ports clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have ports reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports reqN_valid  in  1, for N=0,1: requester N has a job.
REQ-006 SHALL have ports reqN_ready  out  1, for N=0,1: job accepted this cycle.
REQ-007 SHALL have ports reqN_p, reqN_q  in  WIDTH, for N=0,1: primes.
REQ-008 SHALL have ports reqN_ed  in  1, for N=0,1: encrypt_decrypt select.
REQ-009 SHALL have ports reqN_msg  in  2*WIDTH, for N=0,1: message.
REQ-010 SHALL have ports core_p, core_q  out  WIDTH: operands to the shared RSA control core.
REQ-011 SHALL have ports core_encrypt_decrypt  out  1, and core_msg_in  out  2*WIDTH.
REQ-012 SHALL have ports core_reset_inverter, core_reset_mod_exp  out  1: active-high start pulses to the core.
REQ-013 SHALL have ports core_inverter_finish, core_mod_exp_finish  in  1, and core_msg_out  in  2*WIDTH.
REQ-014 SHALL have ports rsp_valid  out  1, rsp_ready  in  1, rsp_id  out  1 (requester), rsp_msg  out  2*WIDTH, rsp_timeout  out  1.

Function
REQ-015 SHALL implement states IDLE, INV_PULSE, INV_WAIT, EXP_PULSE, EXP_WAIT, RESP.
REQ-016 IDLE: if any reqN_valid, SHALL grant round-robin; the grant goes to the requester other than the last one granted when both are valid; requester 0 wins the first contention after reset.
REQ-017 On grant, SHALL assert the granted reqN_ready for exactly one cycle and latch p, q, ed, msg, and id into operand registers.
REQ-018 core_p, core_q, core_encrypt_decrypt, and core_msg_in SHALL be driven from the operand registers continuously; they SHALL be stable from the accept cycle until the next accept.
REQ-019 Key cache: when the latched p, q, ed equal the previous job's and key_valid=1, the next state after accept SHALL be EXP_PULSE; otherwise it SHALL be INV_PULSE.
REQ-020 INV_PULSE/EXP_PULSE: SHALL assert core_reset_inverter or core_reset_mod_exp respectively for exactly one cycle, then go to INV_WAIT or EXP_WAIT.
REQ-021 In the first cycle of INV_WAIT and EXP_WAIT, the finish inputs SHALL be ignored, because stale finish from the previous job is possible.
REQ-022 INV_WAIT SHALL go to EXP_PULSE on core_inverter_finish=1 and set key_valid=1.
REQ-023 EXP_WAIT SHALL go to RESP on core_mod_exp_finish=1, capturing core_msg_out into rsp_msg with rsp_timeout=0.
REQ-024 Watchdog: the counter SHALL clear on entering each WAIT state and increment each WAIT cycle.
REQ-025 When the count equals TIMEOUT_CYCLES without finish, the block SHALL go to RESP with rsp_msg=0, rsp_timeout=1, and key_valid=0.
REQ-026 If finish and the timeout are reached in the same cycle, finish SHALL win.
REQ-027 RESP: rsp_valid SHALL be held at 1 with rsp_id, rsp_msg, and rsp_timeout stable until rsp_ready=1; the transfer occurs on that cycle; next state SHALL be IDLE.
REQ-028 No new job SHALL be accepted while not in IDLE; reqN_ready SHALL be 0 outside IDLE.
REQ-029 reqN_valid dropping after accept SHALL have no effect on the running job.
REQ-030 Minimum latency accept->rsp_valid: 5 cycles plus core time with the inverter phase; 3 cycles plus core time on a cache hit.

Reset
REQ-031 reset_n=0 SHALL asynchronously force IDLE, all outputs 0, operand registers 0, key_valid=0, watchdog 0, and the round-robin pointer to favour requester 0.
REQ-032 Reset asserted mid-job SHALL abandon the job with no response and no pulse glitch; core_reset_* SHALL be 0 during reset.

Verification
REQ-033 Job on req0 (p=113680897410347, q=7999808077935876437321, ed=0, msg=0x7b2800000000), rsp_ready=1 -> one core_reset_inverter pulse, then one core_reset_mod_exp pulse, then rsp_valid with rsp_id=0, rsp_timeout=0, rsp_msg=core_msg_out.
REQ-034 Same job repeated on req1 -> no inverter pulse; mod_exp pulse 1 cycle after accept; rsp_id=1.
REQ-035 req0 and req1 both valid continuously for 4 jobs -> grants 0,1,0,1.
REQ-036 Core model never finishes, TIMEOUT_CYCLES=16 -> rsp_timeout=1 and rsp_msg=0 after 16 WAIT cycles; next identical job re-runs the inverter.
REQ-037 rsp_ready held 0 for 10 cycles in RESP -> rsp_valid stays 1, outputs stable, req*_ready stays 0.
REQ-038 reset_n pulled low during EXP_WAIT -> all outputs 0 immediately; after release, a fresh job runs the inverter phase.
